systolic_feeder: RTL
====================

Name: systolic_feeder

Overview:
- Upstream stage of the N x N systolic MAC array: buffers operand matrices A and B, then drives the array's left edge (rows of A) and top edge (columns of B) with the diagonal skew the array needs.
- Also issues the accumulator clear before each run and reports completion once the last product has propagated.
- The array PEs register on negedge clk. This block registers on posedge clk, giving the array a half-cycle of setup.

Parameters:
- DATA_WIDTH, 8, width of one matrix element.
- N, 4, array dimension (N >= 2); matrices are N x N.
- IDX_W, $clog2(N) (localparam, derived), width of the row/column index.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one element into the matrix buffers.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_row  in  IDX_W  row index of the element.
- wr_col  in  IDX_W  column index of the element.
- wr_data  in  DATA_WIDTH  element value.
- start  in  1  single-cycle request to start a run.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a run.
- mac_clear  out  1  active-high clear for the array's reset input.
- a_out  out  N*DATA_WIDTH  slice i feeds the operand1 input of array row i.
- b_out  out  N*DATA_WIDTH  slice j feeds the operand2 input of array column j.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; busy = 0, done = 0, mac_clear = 0.
  - a_out = 0, b_out = 0, step counter = 0.
  - Matrix buffers are cleared to 0.
- Writes:
  - Accepted only in IDLE: buffer[wr_sel][wr_row][wr_col] <= wr_data.
  - Ignored while busy, and ignored if wr_row >= N or wr_col >= N.
- States:
  - IDLE: a_out/b_out = 0. start=1 -> CLEAR.
  - CLEAR: exactly 1 cycle; mac_clear = 1, busy = 1, outputs 0. -> FEED with t = 0.
  - FEED: 2N-1 cycles, t = 0..2N-2, busy = 1.
    - a_out[i] = A[i][t-i] if 0 <= t-i < N, else 0.
    - b_out[j] = B[t-j][j] if 0 <= t-j < N, else 0.
    - After t = 2N-2 -> DRAIN.
  - DRAIN: N+1 cycles; a_out/b_out = 0, busy = 1. Covers propagation to PE(N-1,N-1) plus the PE's register-then-accumulate delay. -> DONE.
  - DONE: 1 cycle; done = 1, busy = 0, outputs 0. -> IDLE. Array results are valid and stable from this cycle on.
- Latency and timing:
  - start to done = 1 + (2N-1) + (N+1) + 1 = 3N+2 cycles (14 for N=4).
  - Outputs are registered; values for step t appear on the posedge that enters step t.
- Simultaneous events and run semantics:
  - start while not IDLE is ignored and is not queued.
  - start and wr_en in the same IDLE cycle: the write takes effect, and the run uses the new value, because FEED reads buffers only from the cycle after CLEAR.
  - Back-to-back runs: start asserted during DONE is ignored; start must be asserted in IDLE.
  - Buffers persist across runs, so a rerun without new writes reproduces the identical stream.
- Reset mid-run: asserting reset_n low during any state returns to the reset values immediately. The run is abandoned and done is not pulsed.
- Width: elements pass through unmodified; no arithmetic is performed on data.
- Step counter: sized to count to 2N-1 and wraps to 0 on entering DRAIN.

Decomposition:
- Shared package systolic_pkg holds:
  - state encoding (IDLE, CLEAR, FEED, DRAIN, DONE);
  - default DATA_WIDTH and N;
  - a helper constant for run length, 3N+2.
- One natural sub-module: operand_skew_buffer, an N x N register file with a write port and a combinational skewed read for a given t. It is instantiated twice, once for A (row-wise skew) and once for B (column-wise skew). The FSM and counter live in systolic_feeder.

Test Plan:
- Reset: hold reset_n=0 mid-FEED -> busy=0, done=0, mac_clear=0, a_out=b_out=0 immediately (asynchronous); no done pulse afterwards.
- Skew pattern, N=4, A[i][k]=16*i+k+1, B[k][j]=16*k+j+0x81, start -> mac_clear high 1 cycle.
  - At t=0: a_out = {0,0,0,0x01}, b_out = {0,0,0,0x81}.
  - At t=3: a_out[3]=0x31, b_out[3]=0x84.
  - At t=6: only a_out[3]=0x34, b_out[3]=0xB4 are nonzero.
- End-to-end with the MAC array, N=4: A = identity, B[k][j]=k*4+j -> done 14 cycles after start; every mac_result[i][j] = B[i][j].
- A = all 0xFF, B = all 0xFF -> each mac_result = 4*0xFE01 = 0x3F804 truncated to 16 bits = 0xF804. Confirms the feeder introduces no extra or dropped terms.
- Protocol:
  - wr_en during busy (A[0][0] <- 0x55) is ignored.
  - start during FEED is ignored.
  - start together with a write in IDLE (A[0][0] <- 0x07) -> a_out[0]=0x07 at t=0.
  - wr_row=5 with N=5 parameterised -> buffer unchanged.
- Rerun: second start with no new writes -> identical a_out/b_out sequence and done timing as the first run.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : shared constants for the systolic array operand feeder
// Rev 1.0
// ============================================================================
package systolic_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_N          = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Cycles from the start request to the done pulse: clear + feed + drain + done.
  function automatic int run_cycles(input int n);
    return 3 * n + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_skew_buffer.sv
`default_nettype none
// ============================================================================
// operand_skew_buffer : N x N element store with a diagonally skewed read
// Rev 1.0
// ============================================================================
module operand_skew_buffer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  parameter int IDX_W      = $clog2(N),
  parameter int CNT_W      = $clog2(2 * N),
  parameter bit COL_SKEW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_row_i,
  input  logic [IDX_W-1:0]        wr_col_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [CNT_W-1:0]        step_i,
  output logic [N*DATA_WIDTH-1:0] skew_o
);

  logic [DATA_WIDTH-1:0] mem_q [N][N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (wr_en_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // Lane l carries element k = step - l; row-wise for A, column-wise for B.
  for (genvar l = 0; l < N; l++) begin : g_lane
    int                    k;
    logic [DATA_WIDTH-1:0] val;

    always_comb begin
      k   = int'(step_i) - l;
      val = '0;
      if (k >= 0 && k < N) begin
        val = COL_SKEW ? mem_q[k[IDX_W-1:0]][l] : mem_q[l][k[IDX_W-1:0]];
      end
    end

    assign skew_o[l*DATA_WIDTH +: DATA_WIDTH] = val;
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// systolic_feeder : buffers A/B and streams them skewed into the MAC array
// Rev 1.0
// ============================================================================
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int N          = DEFAULT_N,
  localparam int IDX_W      = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [IDX_W-1:0]        wr_row,
  input  logic [IDX_W-1:0]        wr_col,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mac_clear,
  output logic [N*DATA_WIDTH-1:0] a_out,
  output logic [N*DATA_WIDTH-1:0] b_out
);

  localparam int               CNT_W      = $clog2(2 * N);
  localparam int               RUN_LEN    = run_cycles(N);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RUN_LEN - 2 * N - 2);
  localparam int               IDX_SPAN   = 1 << IDX_W;
  // Bit x set when index x addresses a real row/column (handles non power-of-two N).
  localparam logic [IDX_SPAN-1:0] IDX_OK  = {IDX_SPAN{1'b1}} >> (IDX_SPAN - N);

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        step_q, step_d;
  logic                    busy_q, done_q, mac_clear_q;
  logic [N*DATA_WIDTH-1:0] a_out_q, b_out_q;
  logic [N*DATA_WIDTH-1:0] a_skew, b_skew;
  logic                    wr_ok;

  assign wr_ok = wr_en && (state_q == S_IDLE) && IDX_OK[wr_row] && IDX_OK[wr_col];

  operand_skew_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W),
    .COL_SKEW   (1'b0)
  ) u_buf_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (wr_ok && !wr_sel),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .step_i    (step_d),
    .skew_o    (a_skew)
  );

  operand_skew_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W),
    .COL_SKEW   (1'b1)
  ) u_buf_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (wr_ok && wr_sel),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .step_i    (step_d),
    .skew_o    (b_skew)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        step_d  = '0;
      end
      S_FEED: begin
        if (step_q == FEED_LAST) begin
          state_d = S_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the edge entering it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_clear_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      busy_q      <= state_d inside {S_CLEAR, S_FEED, S_DRAIN};
      done_q      <= (state_d == S_DONE);
      mac_clear_q <= (state_d == S_CLEAR);
      a_out_q     <= (state_d == S_FEED) ? a_skew : '0;
      b_out_q     <= (state_d == S_FEED) ? b_skew : '0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_clear = mac_clear_q;
  assign a_out     = a_out_q;
  assign b_out     = b_out_q;

endmodule
`default_nettype wire
